// File: rtl/bsg_cache_dma_to_sram.sv
// ---------------------------------------------------------------------------
// bsg_cache_dma_to_sram
//
// Downstream DMA endpoint for bsg_cache backed by an on-chip, single-port
// SRAM with a one-cycle synchronous read. It serves one block transfer at a
// time: a fill (read) streams a whole block back to the cache, and an
// eviction (write) stores the words whose mask bit is set.
//
// Optional feature macro: BSG_CACHE_DMA_TO_SRAM_STATS_EN
//   defined   -> fill_count_o / evict_count_o count completed transfers
//   undefined -> both count ports are tied to zero, no counter flops
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   dma_pkt_i/_v_i/_yumi_o    {write_not_read, addr, mask} request packet
//   dma_data_o/_v_o/_ready_i  fill words returned to the cache
//   dma_data_i/_v_i/_yumi_o   evicted words arriving from the cache
//   mem_v_o/_w_o/_addr_o      SRAM access enable, write select, word address
//   mem_data_o / mem_data_i   SRAM write data / read data (one cycle later)
//   fill_count_o              completed fills (stats feature)
//   evict_count_o             completed evictions (stats feature)
// ---------------------------------------------------------------------------
module bsg_cache_dma_to_sram #(
   parameter int addr_width_p          = 30,
   parameter int data_width_p          = 64,
   parameter int block_size_in_words_p = 8,
   parameter int els_p                 = 2048,
   localparam int mem_addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int dma_pkt_width_lp     = 1 + addr_width_p + block_size_in_words_p
) (
   input  logic                         clk_i,
   input  logic                         reset_i,

   input  logic [dma_pkt_width_lp-1:0]  dma_pkt_i,
   input  logic                         dma_pkt_v_i,
   output logic                         dma_pkt_yumi_o,

   output logic [data_width_p-1:0]      dma_data_o,
   output logic                         dma_data_v_o,
   input  logic                         dma_data_ready_i,

   input  logic [data_width_p-1:0]      dma_data_i,
   input  logic                         dma_data_v_i,
   output logic                         dma_data_yumi_o,

   output logic                         mem_v_o,
   output logic                         mem_w_o,
   output logic [mem_addr_width_lp-1:0] mem_addr_o,
   output logic [data_width_p-1:0]      mem_data_o,
   input  logic [data_width_p-1:0]      mem_data_i,

   output logic [31:0]                  fill_count_o,
   output logic [31:0]                  evict_count_o
);

   localparam int lgWordBytes = $clog2(data_width_p / 8);
   localparam int lgBlock     = $clog2(block_size_in_words_p);
   localparam int cntWidth    = lgBlock + 1;
   localparam int idxWidth    = (lgBlock > 0) ? lgBlock : 1;

   localparam logic [cntWidth-1:0]          lastWordIdx = cntWidth'(block_size_in_words_p - 1);
   localparam logic [cntWidth-1:0]          blockWords  = cntWidth'(block_size_in_words_p);
   localparam logic [mem_addr_width_lp-1:0] offsetMask  = mem_addr_width_lp'(block_size_in_words_p - 1);

   typedef enum logic [1:0] {
      eIdle,
      eRead,
      eWrite
   } state_e;

   state_e                         state_q, state_d;
   logic [mem_addr_width_lp-1:0]   base_q, base_d;
   logic [block_size_in_words_p-1:0] mask_q, mask_d;
   // wordCnt counts issued reads during a fill and consumed words during an evict
   logic [cntWidth-1:0]            wordCnt_q, wordCnt_d;
   logic [cntWidth-1:0]            sentCnt_q, sentCnt_d;
   logic                           inFlight_q, inFlight_d;

   logic [data_width_p-1:0]        fifoMem_q [2];
   logic [1:0]                     fifoCnt_q, fifoCnt_d;
   logic                           wrPtr_q, wrPtr_d;
   logic                           rdPtr_q, rdPtr_d;

   logic                           pktWriteNotRead;
   logic [addr_width_p-1:0]        pktWordAddr;
   logic [block_size_in_words_p-1:0] pktMask;
   logic                           unusedAddrBits;

   logic                           fifoEmpty;
   logic                           headValid;
   logic [data_width_p-1:0]        headData;
   logic                           deq;
   logic                           deqFifo;
   logic                           enq;
   logic                           issue;
   logic                           lastFillHs;
   logic                           lastEvictYumi;
   logic [mem_addr_width_lp-1:0]   curAddr;

   // Split the request packet. The word address is the byte address scaled
   // down to words; only the bits that fit the SRAM depth are kept, so block
   // addresses alias silently beyond els_p words.
   always_comb begin
      pktWriteNotRead = dma_pkt_i[dma_pkt_width_lp-1];
      pktWordAddr     = dma_pkt_i[block_size_in_words_p +: addr_width_p] >> lgWordBytes;
      pktMask         = dma_pkt_i[block_size_in_words_p-1:0];
      unusedAddrBits  = ^pktWordAddr;
   end

   // Two-entry return FIFO with a fall-through path: when the FIFO is empty
   // the SRAM read data is presented directly, so the first word is visible
   // in the same cycle it comes out of the SRAM. A read is only issued when
   // the FIFO plus the read in flight leave room, so nothing is ever lost
   // while the cache is backpressuring.
   always_comb begin
      fifoEmpty  = (fifoCnt_q == 2'd0);
      headValid  = !fifoEmpty || inFlight_q;
      headData   = fifoEmpty ? mem_data_i : fifoMem_q[rdPtr_q];
      deq        = headValid && dma_data_ready_i;
      deqFifo    = deq && !fifoEmpty;
      enq        = inFlight_q && !(fifoEmpty && deq);
      issue      = (state_q == eRead) && (wordCnt_q != blockWords)
                   && ((fifoCnt_q + {1'b0, inFlight_q}) < 2'd2);
      fifoCnt_d  = fifoCnt_q + 2'(enq) - 2'(deqFifo);
      wrPtr_d    = wrPtr_q ^ enq;
      rdPtr_d    = rdPtr_q ^ deqFifo;
      inFlight_d = issue;
      dma_data_v_o = headValid;
      dma_data_o   = headValid ? headData : '0;
   end

   // Events marking the end of a transfer, shared by the FSM and the stats.
   always_comb begin
      lastFillHs    = (state_q == eRead) && deq && (sentCnt_q == lastWordIdx);
      lastEvictYumi = (state_q == eWrite) && dma_data_v_i && (wordCnt_q == lastWordIdx);
      curAddr       = base_q + mem_addr_width_lp'(wordCnt_q);
   end

   // Transfer FSM: next state and all handshake / SRAM outputs.
   always_comb begin
      state_d         = state_q;
      base_d          = base_q;
      mask_d          = mask_q;
      wordCnt_d       = wordCnt_q;
      sentCnt_d       = sentCnt_q;
      dma_pkt_yumi_o  = 1'b0;
      dma_data_yumi_o = 1'b0;
      mem_v_o         = 1'b0;
      mem_w_o         = 1'b0;
      mem_addr_o      = '0;
      mem_data_o      = '0;

      case (state_q)
         eIdle: begin
            dma_pkt_yumi_o = dma_pkt_v_i;
            if (dma_pkt_v_i) begin
               base_d    = pktWordAddr[mem_addr_width_lp-1:0] & ~offsetMask;
               mask_d    = pktMask;
               wordCnt_d = '0;
               sentCnt_d = '0;
               state_d   = pktWriteNotRead ? eWrite : eRead;
            end
         end

         eRead: begin
            mem_v_o = issue;
            if (issue) begin
               mem_addr_o = curAddr;
               wordCnt_d  = wordCnt_q + 1'b1;
            end
            if (deq) begin
               sentCnt_d = sentCnt_q + 1'b1;
            end
            if (lastFillHs) begin
               state_d = eIdle;
            end
         end

         eWrite: begin
            dma_data_yumi_o = dma_data_v_i;
            if (dma_data_v_i) begin
               if (mask_q[wordCnt_q[idxWidth-1:0]]) begin
                  mem_v_o    = 1'b1;
                  mem_w_o    = 1'b1;
                  mem_addr_o = curAddr;
                  mem_data_o = dma_data_i;
               end
               wordCnt_d = wordCnt_q + 1'b1;
            end
            if (lastEvictYumi) begin
               state_d = eIdle;
            end
         end

         default: begin
            state_d = eIdle;
         end
      endcase
   end

   // Control state. Clearing inFlight on reset drops any SRAM read that
   // returns after reset instead of pushing it into the FIFO.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= eIdle;
         base_q     <= '0;
         mask_q     <= '0;
         wordCnt_q  <= '0;
         sentCnt_q  <= '0;
         inFlight_q <= 1'b0;
         fifoCnt_q  <= '0;
         wrPtr_q    <= 1'b0;
         rdPtr_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         mask_q     <= mask_d;
         wordCnt_q  <= wordCnt_d;
         sentCnt_q  <= sentCnt_d;
         inFlight_q <= inFlight_d;
         fifoCnt_q  <= fifoCnt_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
      end
   end

   // FIFO storage; validity is tracked by the counter, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         fifoMem_q[wrPtr_q] <= mem_data_i;
      end
   end

`ifdef BSG_CACHE_DMA_TO_SRAM_STATS_EN
   logic [31:0] fillCount_q;
   logic [31:0] evictCount_q;

   // Completed-transfer counters; they wrap naturally at 2^32.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fillCount_q  <= '0;
         evictCount_q <= '0;
      end else begin
         if (lastFillHs) begin
            fillCount_q <= fillCount_q + 32'd1;
         end
         if (lastEvictYumi) begin
            evictCount_q <= evictCount_q + 32'd1;
         end
      end
   end

   assign fill_count_o  = fillCount_q;
   assign evict_count_o = evictCount_q;
`else
   assign fill_count_o  = 32'd0;
   assign evict_count_o = 32'd0;
`endif

endmodule

// File: doc/bsg_cache_dma_to_sram.md
Name: bsg_cache_dma_to_sram

Overview:
- Downstream DMA endpoint for bsg_cache. Consumes the cache's DMA packet/data streams (fills and evictions) and drives a single-port, 1-cycle synchronous-read SRAM.
- Serializes one block transfer at a time. This is the synthesizable replacement for the nonsynth DMA model when the cache is backed by on-chip memory.

Parameters:
- addr_width_p, 30, cache byte-address width
- data_width_p, 64, DMA word width in bits; power of 2, at least 8
- block_size_in_words_p, 8, words per block; power of 2
- els_p, 2048, SRAM depth in words; power of 2
- mem_addr_width_lp, derived, `BSG_SAFE_CLOG2(els_p)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- dma_pkt_i  in  1+addr_width_p+block_size_in_words_p  fields {write_not_read (MSB), addr, mask (LSBs)}
- dma_pkt_v_i  in  1  packet valid
- dma_pkt_yumi_o  out  1  packet consumed
- dma_data_o  out  data_width_p  fill word to cache
- dma_data_v_o  out  1  fill word valid
- dma_data_ready_i  in  1  cache can take fill word
- dma_data_i  in  data_width_p  evict word from cache
- dma_data_v_i  in  1  evict word valid
- dma_data_yumi_o  out  1  evict word consumed
- mem_v_o  out  1  SRAM access enable
- mem_w_o  out  1  1 = write, 0 = read
- mem_addr_o  out  mem_addr_width_lp  SRAM word address
- mem_data_o  out  data_width_p  SRAM write data
- mem_data_i  in  data_width_p  SRAM read data, valid the cycle after a read
- fill_count_o  out  32  completed fills (optional feature)
- evict_count_o  out  32  completed evictions (optional feature)

Behaviour:
- Address mapping
  - word_addr = addr >> lg(data_width_p/8).
  - Block-offset bits are forced to zero.
  - mem_addr_o = (word_addr + word_cnt) mod els_p. Upper bits are truncated, so addresses wrap silently.
- States: IDLE, READ, WRITE.
  - IDLE: dma_pkt_yumi_o = dma_pkt_v_i. On accept, latch addr and mask, clear word_cnt, and go to READ or WRITE per write_not_read.
  - dma_pkt_yumi_o is 0 in READ and WRITE.
- READ (fill)
  - Issues SRAM reads for words 0..block_size_in_words_p-1 in order, starting the cycle after accept.
  - Read data is captured into a 2-entry FIFO one cycle after issue.
  - A read is issued only if (fifo_count + reads_in_flight) < 2. This gives no loss under backpressure.
  - dma_data_v_o = FIFO not empty. Dequeue when dma_data_v_o & dma_data_ready_i.
  - Earliest dma_data_v_o is 2 cycles after the accept cycle. Under full throughput, words are 1 per cycle.
  - The mask is ignored: all words are returned.
  - Return to IDLE in the cycle after the last word's handshake.
- WRITE (evict)
  - dma_data_yumi_o = dma_data_v_i.
  - Same cycle: mem_v_o = 1 and mem_w_o = 1 only if mask[word_cnt] = 1. Otherwise the word is consumed and dropped.
  - word_cnt increments on each yumi. After the last word, go to IDLE. The next packet can be accepted the following cycle.
- Ordering: one packet at a time, so a fill after an eviction of the same block returns the written data.
- Reset (any state, including mid-block)
  - State goes to IDLE. FIFO, word_cnt and in-flight counters clear.
  - All outputs are 0, counters included.
  - Read data returning after reset is discarded.
- mem_data_o = dma_data_i when writing, otherwise don't-care.
- dma_data_i is ignored outside WRITE.

Optional Feature:
- Macro: BSG_CACHE_DMA_TO_SRAM_STATS_EN.
- Defined
  - fill_count_o increments in the cycle the last fill word handshakes.
  - evict_count_o increments on the last evict word yumi.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan (data_width_p = 64, block_size_in_words_p = 8, els_p = 2048):
- Evict addr 0x40, mask 0xFF, data 1..8 -> SRAM writes to word addrs 8..15 with data 1..8, one per cycle; dma_data_yumi_o high 8 cycles.
- Then fill addr 0x47 -> offset is masked; dma_data_o returns 1..8 in order; first valid 2 cycles after pkt accept.
- Evict addr 0x40, mask 0x0F, data 0xA..0x11 -> only addrs 8..11 written; a later fill returns A,B,C,D,5,6,7,8.
- Fill with dma_data_ready_i held low 6 cycles after accept -> at most 2 SRAM reads issued; all 8 words later delivered in order, no duplicates.
- Evict/fill addr 0x4040 -> word_addr 0x808 wraps to mem_addr 8.
- Reset asserted after 3 fill words -> all outputs 0 next cycle; a new fill at 0x40 returns 8 correct words; with STATS_EN, fill_count_o = 1 after completion.
